// File: rtl/axi_lite_shadow_regfile_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_shadow_regfile_pkg
//   Shared definitions for the pixel-pipeline parameter register file:
//   AXI response codes, write/read FSM state encodings and the word indices
//   of the well-known generator parameters.
// -----------------------------------------------------------------------------
package axi_lite_shadow_regfile_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_DATA = 3'd1,  // address accepted, waiting for data
    W_ADDR = 3'd2,  // data accepted, waiting for address
    W_EXEC = 3'd3,  // single cycle in which the staging bank is written
    W_RESP = 3'd4
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_t;

  // Word indices of the generator parameters
  localparam int X_OFFSET = 0;
  localparam int Y_OFFSET = 1;
  localparam int ZOOM     = 2;
  localparam int ITER_MAX = 3;

endpackage

// File: rtl/axi_lite_shadow_regfile_wr_ctrl.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_ctrl
//   AXI4-Lite write channel controller. Accepts AW and W in any order,
//   captures each on its handshake, spends one cycle in W_EXEC presenting the
//   write to the register banks, then holds the B response until bready.
// Ports
//   i_clk, i_resetn             clock, synchronous active-low reset
//   i_aw*, o_awready            write address channel
//   i_w*,  o_wready             write data channel
//   o_bresp, o_bvalid, i_bready write response channel
//   o_wr_en                     one-cycle strobe: W_EXEC targeting an RW register
//   o_wr_idx/_data/_strb        captured word index, data and byte strobes
// -----------------------------------------------------------------------------
module axi_lite_wr_ctrl
  import axi_lite_shadow_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic [ADDR_WIDTH-1:0]     i_awaddr,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [1:0]                o_bresp,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  output logic                      o_wr_en,
  output logic [ADDR_WIDTH-3:0]     o_wr_idx,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  output logic [DATA_WIDTH/8-1:0]   o_wr_strb
);

  localparam int          IDX_W    = ADDR_WIDTH - 2;
  localparam logic [31:0] NUM_RW_U = 32'(NUM_RW);

  wr_state_t               r_state;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH/8-1:0] r_strb;

  logic                    w_in_rw;
  logic                    w_unused_awaddr_lsb;

  // Full word index is compared, so addresses beyond the RW range never alias
  assign w_in_rw             = 32'(r_idx) < NUM_RW_U;
  assign w_unused_awaddr_lsb = ^i_awaddr[1:0];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_OKAY;
      r_idx     <= '0;
      r_data    <= '0;
      r_strb    <= '0;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (i_awvalid) r_idx <= i_awaddr[ADDR_WIDTH-1:2];
          if (i_wvalid) begin
            r_data <= i_wdata;
            r_strb <= i_wstrb;
          end
          if (i_awvalid && i_wvalid) begin
            r_state   <= W_EXEC;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else if (i_awvalid) begin
            r_state   <= W_DATA;
            r_awready <= 1'b0;
          end else if (i_wvalid) begin
            r_state  <= W_ADDR;
            r_wready <= 1'b0;
          end
        end
        W_DATA: begin
          if (i_wvalid) begin
            r_data   <= i_wdata;
            r_strb   <= i_wstrb;
            r_state  <= W_EXEC;
            r_wready <= 1'b0;
          end
        end
        W_ADDR: begin
          if (i_awvalid) begin
            r_idx     <= i_awaddr[ADDR_WIDTH-1:2];
            r_state   <= W_EXEC;
            r_awready <= 1'b0;
          end
        end
        W_EXEC: begin
          r_state  <= W_RESP;
          r_bvalid <= 1'b1;
          r_bresp  <= w_in_rw ? AXI_OKAY : AXI_SLVERR;
        end
        W_RESP: begin
          if (i_bready) begin
            r_state   <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_wr_en   = (r_state == W_EXEC) && w_in_rw;
  assign o_wr_idx  = r_idx;
  assign o_wr_data = r_data;
  assign o_wr_strb = r_strb;

endmodule

// File: rtl/axi_lite_shadow_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_shadow_regfile
//   AXI4-Lite register file holding the pixel generator's parameters.
//   AXI writes land in a staging bank; the active bank seen by the generator
//   copies staging only on frame_commit, so parameters never change mid-frame.
//   Word indices NUM_RW.. map to read-only hardware status registers.
// Ports
//   s_axi_lite_aclk, axi_resetn  clock, synchronous active-low reset
//   s_axi_lite_aw*/w*/b*         AXI4-Lite write channels
//   s_axi_lite_ar*/r*            AXI4-Lite read channels
//   status_in                    RO register values, sampled when a read fetches
//   frame_commit                 start-of-frame pulse; transfers staging to active
//   regs_active                  active bank, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   commit_pending               staging has been written since the last transfer
// -----------------------------------------------------------------------------
module axi_lite_shadow_regfile
  import axi_lite_shadow_regfile_pkg::*;
#(
  parameter int                            AXI_LITE_ADDR_WIDTH = 8,
  parameter int                            DATA_WIDTH          = 32,
  parameter int                            NUM_RW              = 8,
  parameter int                            NUM_RO              = 2,
  parameter bit                            SHADOW              = 1'b1,
  parameter logic [NUM_RW*DATA_WIDTH-1:0]  RST_VAL             = '0
) (
  input  logic                             s_axi_lite_aclk,
  input  logic                             axi_resetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_lite_awaddr,
  input  logic                             s_axi_lite_awvalid,
  output logic                             s_axi_lite_awready,
  input  logic [DATA_WIDTH-1:0]            s_axi_lite_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_axi_lite_wstrb,
  input  logic                             s_axi_lite_wvalid,
  output logic                             s_axi_lite_wready,
  output logic [1:0]                       s_axi_lite_bresp,
  output logic                             s_axi_lite_bvalid,
  input  logic                             s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_lite_araddr,
  input  logic                             s_axi_lite_arvalid,
  output logic                             s_axi_lite_arready,
  output logic [DATA_WIDTH-1:0]            s_axi_lite_rdata,
  output logic [1:0]                       s_axi_lite_rresp,
  output logic                             s_axi_lite_rvalid,
  input  logic                             s_axi_lite_rready,
  input  logic [NUM_RO*DATA_WIDTH-1:0]     status_in,
  input  logic                             frame_commit,
  output logic [NUM_RW*DATA_WIDTH-1:0]     regs_active,
  output logic                             commit_pending
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = AXI_LITE_ADDR_WIDTH - 2;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [NUM_RW-1:0]     w_reg_we;
  logic                  w_any_we;

  axi_lite_wr_ctrl #(
    .ADDR_WIDTH (AXI_LITE_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_RW     (NUM_RW)
  ) u_wr_ctrl (
    .i_clk      (s_axi_lite_aclk),
    .i_resetn   (axi_resetn),
    .i_awaddr   (s_axi_lite_awaddr),
    .i_awvalid  (s_axi_lite_awvalid),
    .o_awready  (s_axi_lite_awready),
    .i_wdata    (s_axi_lite_wdata),
    .i_wstrb    (s_axi_lite_wstrb),
    .i_wvalid   (s_axi_lite_wvalid),
    .o_wready   (s_axi_lite_wready),
    .o_bresp    (s_axi_lite_bresp),
    .o_bvalid   (s_axi_lite_bvalid),
    .i_bready   (s_axi_lite_bready),
    .o_wr_en    (w_wr_en),
    .o_wr_idx   (w_wr_idx),
    .o_wr_data  (w_wr_data),
    .o_wr_strb  (w_wr_strb)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RW; gi++) begin : g_we
      assign w_reg_we[gi] = w_wr_en && (32'(w_wr_idx) == 32'(gi));
    end
  endgenerate

  // A write with no strobes set changes nothing, so it must not arm a commit
  assign w_any_we = w_wr_en && (|w_wr_strb);

  // ---------------------------------------------------------------------------
  // Staging bank
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_staging [NUM_RW];

  always_ff @(posedge s_axi_lite_aclk) begin
    if (!axi_resetn) begin
      for (int i = 0; i < NUM_RW; i++) begin
        r_staging[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (w_reg_we[i] && w_wr_strb[k]) begin
            r_staging[i][k*8 +: 8] <= w_wr_data[k*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank
  // ---------------------------------------------------------------------------
  generate
    if (SHADOW) begin : g_shadow
      logic [DATA_WIDTH-1:0] r_active [NUM_RW];
      logic                  r_pending;

      // A commit coinciding with W_EXEC copies the pre-write staging values
      // (non-blocking), and the new write keeps pending armed for next frame.
      always_ff @(posedge s_axi_lite_aclk) begin
        if (!axi_resetn) begin
          for (int i = 0; i < NUM_RW; i++) begin
            r_active[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
          end
          r_pending <= 1'b0;
        end else begin
          if (frame_commit && r_pending) begin
            for (int i = 0; i < NUM_RW; i++) begin
              r_active[i] <= r_staging[i];
            end
          end
          if (w_any_we) begin
            r_pending <= 1'b1;
          end else if (frame_commit && r_pending) begin
            r_pending <= 1'b0;
          end
        end
      end

      for (gi = 0; gi < NUM_RW; gi++) begin : g_out
        assign regs_active[gi*DATA_WIDTH +: DATA_WIDTH] = r_active[gi];
      end
      assign commit_pending = r_pending;
    end else begin : g_direct
      for (gi = 0; gi < NUM_RW; gi++) begin : g_out
        assign regs_active[gi*DATA_WIDTH +: DATA_WIDTH] = r_staging[gi];
      end
      assign commit_pending = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_t             r_rd_state;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [IDX_W-1:0]      r_rd_idx;

  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]            w_rd_resp;
  logic                  w_unused_araddr_lsb;

  assign w_unused_araddr_lsb = ^s_axi_lite_araddr[1:0];

  // Unmapped indices fall through to zero data with SLVERR
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = AXI_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (32'(r_rd_idx) == 32'(i)) begin
        w_rd_data = r_staging[i];
        w_rd_resp = AXI_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (32'(r_rd_idx) == 32'(NUM_RW + j)) begin
        w_rd_data = status_in[j*DATA_WIDTH +: DATA_WIDTH];
        w_rd_resp = AXI_OKAY;
      end
    end
  end

  always_ff @(posedge s_axi_lite_aclk) begin
    if (!axi_resetn) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= AXI_OKAY;
      r_rd_idx   <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (s_axi_lite_arvalid) begin
            r_rd_idx   <= s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2];
            r_rd_state <= R_FETCH;
            r_arready  <= 1'b0;
          end
        end
        R_FETCH: begin
          r_rdata    <= w_rd_data;
          r_rresp    <= w_rd_resp;
          r_rvalid   <= 1'b1;
          r_rd_state <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_lite_rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: begin
          r_rvalid   <= 1'b0;
          r_arready  <= 1'b1;
          r_rd_state <= R_IDLE;
        end
      endcase
    end
  end

  assign s_axi_lite_arready = r_arready;
  assign s_axi_lite_rvalid  = r_rvalid;
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;

endmodule
